// File: rtl/stripes_pkg.sv
// Shared constants and helpers for the Stripes bit-serial datapath.
// Used by both the transposer sequencing logic and the detransposer.
package stripes_pkg;

    localparam int unsigned DEF_WL       = 16;
    localparam int unsigned DEF_WORDS    = 16;
    localparam int unsigned DEF_SEL_BITS = 4;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

    // A precision of zero or beyond the word length means "full word".
    function automatic int unsigned clamp_precision(input int unsigned prec,
                                                    input int unsigned wl);
        return ((prec == 0) || (prec > wl)) ? wl : prec;
    endfunction

endpackage

// File: rtl/detransposer_lane.sv
// One word of the detransposer: accumulates one bit per accepted plane and
// produces the completed, optionally sign-extended word on the last plane.
module detransposer_lane
    import stripes_pkg::*;
#(
    parameter int unsigned WL       = DEF_WL,
    parameter int unsigned CW       = DEF_SEL_BITS + 1,
    parameter int unsigned SIGN_EXT = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          first,
    input  logic          bit_in,
    input  logic [CW-1:0] idx,
    input  logic [CW-1:0] prec,
    output logic [WL-1:0] word_c
);

    logic [WL-1:0] acc;

    // Plane 0 clears every other bit so a previous block cannot leak through.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (en) begin
            for (int unsigned b = 0; b < WL; b++) begin
                if (CW'(b) == idx) begin
                    acc[b] <= bit_in;
                end else if (first) begin
                    acc[b] <= 1'b0;
                end
            end
        end
    end

    // Merge the current plane into the accumulator and extend above prec.
    always_comb begin
        word_c = '0;
        for (int unsigned b = 0; b < WL; b++) begin
            if (CW'(b) < prec) begin
                if (CW'(b) == idx) begin
                    word_c[b] = bit_in;
                end else begin
                    word_c[b] = first ? 1'b0 : acc[b];
                end
            end else begin
                word_c[b] = (SIGN_EXT != 0) ? bit_in : 1'b0;
            end
        end
    end

endmodule

// File: rtl/detransposer.sv
// Bit-serial to bit-parallel reassembler: collects LSB-first bit-planes into
// WORDS parallel words and presents each block through a valid/ready register.
module detransposer
    import stripes_pkg::*;
#(
    parameter int unsigned SEL_BITS = DEF_SEL_BITS,
    parameter int unsigned WL       = DEF_WL,
    parameter int unsigned WORDS    = DEF_WORDS,
    parameter int unsigned SIGN_EXT = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORDS-1:0]      stream,
    input  logic [SEL_BITS:0]     precision,
    output logic [WORDS*WL-1:0]   out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int unsigned CW = SEL_BITS + 1;

    logic [CW-1:0] cnt;
    logic [CW-1:0] p_lat;
    out_state_e    out_state;

    logic [CW-1:0] p_in_c;
    logic [CW-1:0] p_cur_c;
    logic          first_c;
    logic          last_c;
    logic          accept_c;
    logic [WL-1:0] lane_word [WORDS];

    // The incoming precision only matters while waiting for plane 0.
    assign p_in_c   = CW'(clamp_precision(32'(precision), WL));
    assign first_c  = (cnt == '0);
    assign p_cur_c  = first_c ? p_in_c : p_lat;
    assign last_c   = (cnt == (p_cur_c - CW'(1)));
    assign out_valid = (out_state == OUT_FULL);

    // Only the last plane can stall, and only if the held block is not draining.
    assign in_ready = !(last_c && out_valid && !out_ready);
    assign accept_c = in_valid && in_ready;

    for (genvar i = 0; i < int'(WORDS); i++) begin : g_lane
        detransposer_lane #(
            .WL       (WL),
            .CW       (CW),
            .SIGN_EXT (SIGN_EXT)
        ) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .en     (accept_c),
            .first  (first_c),
            .bit_in (stream[i]),
            .idx    (cnt),
            .prec   (p_cur_c),
            .word_c (lane_word[i])
        );
    end

    // Plane sequencing: cnt walks 0..P-1, P is captured with plane 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            p_lat <= CW'(WL);
        end else if (accept_c) begin
            if (first_c) begin
                p_lat <= p_in_c;
            end
            cnt <= last_c ? '0 : (cnt + CW'(1));
        end
    end

    // Output register; a refill on the last plane wins over a plain drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_state <= OUT_EMPTY;
            out_data  <= '0;
        end else begin
            case (out_state)
                OUT_EMPTY: begin
                    if (accept_c && last_c) begin
                        out_state <= OUT_FULL;
                    end
                end
                OUT_FULL: begin
                    if (!(accept_c && last_c) && out_ready) begin
                        out_state <= OUT_EMPTY;
                    end
                end
                default: out_state <= OUT_EMPTY;
            endcase
            if (accept_c && last_c) begin
                for (int unsigned i = 0; i < WORDS; i++) begin
                    out_data[i*WL +: WL] <= lane_word[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_detransposer.sv
// Scoreboard bench for detransposer: one zero-extending and one sign-extending
// instance, expected blocks queued at stimulus time and popped on handshake.
module tb_detransposer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, sx_valid;
    logic [15:0]  stream;
    logic [4:0]   precision;
    logic         out_ready;
    logic         in_ready, sx_in_ready;
    logic [255:0] out_data, sx_data;
    logic         out_valid, sx_out_valid;

    int n_cmp = 0;
    int n_bad = 0;
    logic [255:0] exp_q [$];
    logic [255:0] exp_sx_q [$];

    always #5 clk = ~clk;

    detransposer #(.SEL_BITS(4), .WL(16), .WORDS(16), .SIGN_EXT(0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .stream(stream), .precision(precision), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    detransposer #(.SEL_BITS(4), .WL(16), .WORDS(16), .SIGN_EXT(1)) dut_sx (
        .clk(clk), .rst_n(rst_n), .in_valid(sx_valid), .in_ready(sx_in_ready),
        .stream(stream), .precision(precision), .out_data(sx_data),
        .out_valid(sx_out_valid), .out_ready(out_ready)
    );

    function automatic logic [255:0] mk4(input logic [15:0] w0, input logic [15:0] w1,
                                         input logic [15:0] w2, input logic [15:0] w3);
        logic [255:0] r = '0;
        r[15:0]  = w0;
        r[31:16] = w1;
        r[47:32] = w2;
        r[63:48] = w3;
        return r;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitors: every output handshake must match the oldest queued block.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_block: got %h expected none", out_data);
            end else begin
                chk("block", out_data, exp_q.pop_front());
            end
        end
        if (rst_n && sx_out_valid && out_ready) begin
            if (exp_sx_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_sx_block: got %h expected none", sx_data);
            end else begin
                chk("sx_block", sx_data, exp_sx_q.pop_front());
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    // Present one plane and hold it until accepted (bounded).
    task automatic plane(input logic [15:0] s, input logic [4:0] p, input bit both);
        bit rdy;
        bit done;
        done = 1'b0;
        in_valid = 1'b1; sx_valid = both; stream = s; precision = p;
        for (int t = 0; t < 40 && !done; t++) begin
            @(negedge clk);
            rdy = in_ready;
            cyc();
            done = rdy;
        end
        in_valid = 1'b0; sx_valid = 1'b0;
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL plane_accept: got timeout expected accept of %h", s);
        end
    endtask

    initial begin
        logic [15:0] base [4];
        base[0] = 16'h0009; base[1] = 16'h000F; base[2] = 16'h0003; base[3] = 16'h0007;
        rst_n = 1'b0; in_valid = 1'b0; sx_valid = 1'b0; stream = '0;
        precision = 5'd16; out_ready = 1'b1;
        idle(2);
        chk("reset_out_valid", 256'(out_valid), 256'(0));
        chk("reset_out_data", out_data, '0);
        rst_n = 1'b1;
        idle(1);
        chk("reset_in_ready", 256'(in_ready), 256'(1));

        // Full precision, four active lanes.
        for (int k = 0; k < 16; k++) begin
            if (k == 15) exp_q.push_back(mk4(16'h000F, 16'h000E, 16'h000A, 16'h0003));
            plane((k < 4) ? base[k] : 16'h0000, 5'd16, 1'b0);
        end
        chk("full_out_valid", 256'(out_valid), 256'(1));
        idle(2);

        // Precision 4, both extension modes on the same planes.
        for (int k = 0; k < 4; k++) begin
            if (k == 3) begin
                exp_q.push_back(mk4(16'h000F, 16'h000E, 16'h000A, 16'h0003));
                exp_sx_q.push_back(mk4(16'hFFFF, 16'hFFFE, 16'hFFFA, 16'h0003));
            end
            plane(base[k], 5'd4, 1'b1);
        end
        idle(2);

        // Backpressure with precision 2.
        out_ready = 1'b0;
        exp_q.push_back(mk4(16'h0001, 16'h0002, 16'h0000, 16'h0000));
        plane(16'h0001, 5'd2, 1'b0);
        plane(16'h0002, 5'd2, 1'b0);
        chk("bp_first_valid", 256'(out_valid), 256'(1));
        plane(16'h0003, 5'd2, 1'b0);
        in_valid = 1'b1; stream = 16'h0000; precision = 5'd2;
        @(negedge clk);
        chk("bp_in_ready_low", 256'(in_ready), 256'(0));
        chk("bp_data_hold", out_data, mk4(16'h0001, 16'h0002, 16'h0000, 16'h0000));
        idle(2);
        @(negedge clk);
        chk("bp_data_hold2", out_data, mk4(16'h0001, 16'h0002, 16'h0000, 16'h0000));
        cyc();
        out_ready = 1'b1;
        exp_q.push_back(mk4(16'h0001, 16'h0001, 16'h0000, 16'h0000));
        @(negedge clk);
        chk("bp_in_ready_high", 256'(in_ready), 256'(1));
        cyc();
        in_valid = 1'b0;
        chk("bp_refill_valid", 256'(out_valid), 256'(1));
        idle(2);

        // Precision 0 means 16 planes.
        for (int k = 0; k < 16; k++) begin
            if (k == 15) exp_q.push_back(mk4(16'h7FFF, 16'h8000, 16'h0000, 16'h0000));
            plane((k == 15) ? 16'h0002 : 16'h0001, 5'd0, 1'b0);
            if (k == 14) chk("p0_not_early", 256'(out_valid), 256'(0));
        end
        idle(2);

        // Precision 1: every plane is a block.
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back((k == 3) ? mk4(16'h0000, 16'h0001, 16'h0000, 16'h0000)
                                     : mk4(16'h0001, 16'h0000, 16'h0000, 16'h0000));
            plane((k == 3) ? 16'h0002 : 16'h0001, 5'd1, 1'b0);
        end
        idle(2);

        // Precision change mid-block is ignored until the next plane 0.
        for (int k = 0; k < 8; k++) begin
            if (k == 7) exp_q.push_back(mk4(16'h0081, 16'h0000, 16'h0000, 16'h0000));
            plane((k == 0 || k == 7) ? 16'h0001 : 16'h0000, (k < 2) ? 5'd8 : 5'd3, 1'b0);
            if (k == 2) chk("prec_change_not_early", 256'(out_valid), 256'(0));
        end
        idle(2);

        // Mid-block reset discards the partial block and the held output.
        for (int k = 0; k < 5; k++) plane(16'hFFFF, 5'd16, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 256'(out_valid), 256'(0));
        chk("midrst_out_data", out_data, '0);
        idle(1);
        rst_n = 1'b1;
        idle(1);
        for (int k = 0; k < 16; k++) begin
            if (k == 15) exp_q.push_back(mk4(16'h0000, 16'h0000, 16'h0001, 16'h0000));
            plane((k == 0) ? 16'h0004 : 16'h0000, 5'd16, 1'b0);
        end
        idle(2);

        // Gapped input gives the same block, only after the 16th plane.
        for (int k = 0; k < 16; k++) begin
            if (k == 15) exp_q.push_back(mk4(16'h000F, 16'h000E, 16'h000A, 16'h0003));
            plane((k < 4) ? base[k] : 16'h0000, 5'd16, 1'b0);
            if (k == 14) chk("gap_not_early", 256'(out_valid), 256'(0));
            if (k == 15) chk("gap_out_valid", 256'(out_valid), 256'(1));
            idle(1);
        end
        idle(4);

        chk("queue_drained", 256'(exp_q.size()), 256'(0));
        chk("sx_queue_drained", 256'(exp_sx_q.size()), 256'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
